systolic_skew_feeder: RTL

Upstream stage of the 4x4 systolic matrix-multiply array. Holds operand matrices A and B in a register buffer loaded through a simple write port. On `start`, it clears the array accumulators and streams the operands diagonally skewed into the array's left and top edges, with zero padding. It then waits out the array's fill latency and pulses `done` when every C[r][c] = Σk A[r][k]·B[k][c] is valid at the PE outputs.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/skew_lane_mux.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared parameters and FSM encoding for the systolic array front end.
package systolic_pkg;
    localparam int N         = 4;
    localparam int DW        = 32;
    localparam int PE_LAT    = 1;
    localparam int FEED_CYC  = 2*N - 1;
    localparam int DRAIN_CYC = N - 1 + PE_LAT;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;
endpackage

// File: rtl/skew_lane_mux.sv
// One edge lane of the diagonal skew: selects vec[step - lane] inside the
// valid window, zero padding outside it.
module skew_lane_mux #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 3
) (
    input  logic [$clog2(N)-1:0]  lane,
    input  logic [CW-1:0]         step,
    input  logic [N-1:0][DW-1:0]  vec,
    output logic [DW-1:0]         operand
);
    localparam int LW = $clog2(N);

    logic [CW-1:0] idx;

    always_comb begin
        idx     = step - CW'(lane);
        operand = '0;
        // Unsigned wrap of idx is harmless: the step >= lane guard runs first.
        if (step >= CW'(lane) && idx < CW'(N))
            operand = vec[idx[LW-1:0]];
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand buffer plus sequencer that clears the array and streams A/B
// diagonally skewed into its left and top edges.
module systolic_skew_feeder #(
    parameter int N      = systolic_pkg::N,
    parameter int DW     = systolic_pkg::DW,
    parameter int PE_LAT = systolic_pkg::PE_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [$clog2(N)-1:0]  wr_col,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  acc_clr,
    output logic [N*DW-1:0]       row_bus,
    output logic [N*DW-1:0]       col_bus,
    output logic                  feed_valid,
    output logic                  done
);
    import systolic_pkg::*;

    localparam int LW = $clog2(N);
    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] FEED_END  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_END = CW'(N - 2 + PE_LAT);

    feeder_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [N-1:0][N-1:0][DW-1:0] mat_a, mat_b, b_cols;
    logic [N*DW-1:0] row_nxt, col_nxt;

    // Operand buffer is intentionally not reset so it survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ready) begin
            if (wr_sel) mat_b[wr_row][wr_col] <= wr_data;
            else        mat_a[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (start) begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
            CLEAR: begin
                state_nxt = FEED;
                cnt_nxt   = '0;
            end
            FEED: if (cnt == FEED_END) begin
                state_nxt = DRAIN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            DRAIN: if (cnt == DRAIN_END) begin
                state_nxt = DONE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Lanes look at cnt_nxt so the registered bus shows step t during FEED step t.
    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_cols[i][k] = mat_b[k][i];
        end

        skew_lane_mux #(.N(N), .DW(DW), .CW(CW)) u_row (
            .lane    (LW'(i)),
            .step    (cnt_nxt),
            .vec     (mat_a[i]),
            .operand (row_nxt[i*DW +: DW])
        );

        skew_lane_mux #(.N(N), .DW(DW), .CW(CW)) u_col (
            .lane    (LW'(i)),
            .step    (cnt_nxt),
            .vec     (b_cols[i]),
            .operand (col_nxt[i*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            done       <= 1'b0;
            row_bus    <= '0;
            col_bus    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy       <= (state_nxt != IDLE);
            acc_clr    <= (state_nxt == CLEAR);
            feed_valid <= (state_nxt == FEED);
            done       <= (state_nxt == DONE);
            row_bus    <= (state_nxt == FEED) ? row_nxt : '0;
            col_bus    <= (state_nxt == FEED) ? col_nxt : '0;
        end
    end

    assign wr_ready = ~busy;
endmodule
